fp_writeback_stage: RTL and testbench
=====================================

// Module: fp_writeback_stage
// PURPOSE
//  Pipeline register and commit logic directly downstream of the FP execute stage. Captures the FP result
//  and exception flags at the EX/WB boundary and drives the FP or integer register-file write port.
//  Accumulates the sticky fflags into fcsr and owns the fcsr/frm/fflags CSRs.
//  Supplies the dynamic rounding mode (frm) back to decode/execute.
// PARAMETERS
//  DATA_W     32      FP/integer result width (RV32F)
//  RESET_FRM  3'b000  frm value loaded on reset (RNE)
// PORTS
//  clk             in   1   clock, rising edge
//  rst_n           in   1   asynchronous active-low reset
//  stall           in   1   hold EX/WB register contents
//  flush           in   1   kill the instruction being captured
//  ex_valid        in   1   EX stage holds a valid FP instruction
//  ex_fp_result    in   32  result from FP execute
//  ex_fflags       in   5   {NV,DZ,OF,UF,NX} from FP execute
//  ex_rd           in   5   destination register index
//  ex_fp_we        in   1   result targets the FP register file
//  ex_int_we       in   1   result targets the integer register file (fp_to_int, compare, class, fmv.x.w)
//  ex_flags_en     in   1   instruction may raise fflags
//  csr_en          in   1   CSR access this cycle (issued from WB-side CSR unit)
//  csr_op          in   2   00 none, 01 write, 10 set, 11 clear
//  csr_addr        in   12  0x001 fflags, 0x002 frm, 0x003 fcsr
//  csr_wdata       in   32  CSR operand
//  csr_rdata       out  32  combinational read of the addressed CSR (pre-update value)
//  wb_valid        out  1   WB register holds a valid instruction
//  wb_rd           out  5   destination index
//  wb_data         out  32  write-back data
//  wb_fp_we        out  1   = wb_valid & captured ex_fp_we
//  wb_int_we       out  1   = wb_valid & captured ex_int_we
//  frm             out  3   current dynamic rounding mode
//  fflags          out  5   current accrued exception flags
// BEHAVIOUR
//  - Reset (rst_n=0, async): wb_valid, wb_rd, wb_data, wb_fp_we, wb_int_we = 0; fflags = 0; frm = RESET_FRM.
//    csr_rdata is combinational and reflects the reset state.
//  - Latency: 1 cycle EX->WB. capture = ex_valid & ~stall & ~flush.
//  - Capture: wb_rd, wb_data, the write enables, and wb_valid<=1 load from the ex_* inputs.
//  - Priority: flush > stall > capture.
//      flush: wb_valid, wb_fp_we, wb_int_we <= 0, regardless of stall.
//      stall (no flush): every WB register holds.
//      ~ex_valid & ~stall & ~flush: wb_valid and the write enables <= 0.
//  - Power: wb_data and wb_rd load only on capture (no toggling on bubbles or stalls).
//  - ex_fp_we & ex_int_we both 1: illegal. wb_int_we wins; wb_fp_we is forced to 0.
//  - Flag accrual: on capture & ex_flags_en, fflags |= ex_fflags (sticky). Flags are never cleared except by
//    CSR or reset. A flushed or stalled instruction never accrues flags.
//  - CSR access is 1 write cycle. 'new' = wdata (write), old|wdata (set), old&~wdata (clear).
//      0x001: fflags = new[4:0].
//      0x002: frm = new[2:0].
//      0x003: fflags = new[4:0], frm = new[7:5].
//      Unlisted address: rdata = 0, no state change.
//      csr_rdata: 0x001 -> {27'b0,fflags}; 0x002 -> {29'b0,frm}; 0x003 -> {24'b0,frm,fflags}.
//  - Simultaneous CSR access and flag accrual, same cycle: the CSR update is applied first, then the
//    accrued ex_fflags are ORed in. The captured FP op is younger than the CSR instruction.
//  - frm reserved values 101/110 are stored as written. Illegal-rm trapping belongs to decode.
//  - frm and fflags change only on clock edges. There are no combinational paths from ex_* to any output
//    except through csr_rdata; csr_rdata depends only on csr_addr and state.
// TESTING
//  1 Reset: hold rst_n=0, then release -> all wb_* = 0, fflags=0, frm=000, csr_rdata(0x003)=0.
//  2 Capture: ex_valid=1, fp_we=1, rd=5, result=0x3F800000 -> next cycle wb_valid=1, wb_fp_we=1,
//    wb_rd=5, wb_data=0x3F800000; bubble on the following cycle -> wb_valid=0, wb_data held.
//  3 Stall then flush: capture rd=7; stall 3 cycles -> outputs held; assert flush together with stall
//    -> wb_valid=0; ex_fflags=5'b00001 presented with flush -> fflags unchanged.
//  4 Accrual: ops with flags 5'b10000, then 5'b00001 -> fflags=5'b10001;
//    csr clear 0x001, wdata=0x10 -> fflags=5'b00001.
//  5 Same-cycle collision: csr write 0x003, wdata=0x000000E0 while capturing an op with flags 5'b00100
//    -> frm=111, fflags=5'b00100; csr_rdata(0x003)=0x000000E4.
//  6 Async reset mid-operation: assert rst_n low between clock edges while wb_valid=1 and fflags!=0
//    -> all outputs clear immediately, without waiting for clk.

Source files
------------

// File: rtl/fp_writeback_stage_if.sv
// EX -> WB boundary bundle: the FP execute result, its routing/flag qualifiers,
// and the pipeline control (stall/flush) that governs the capture.
interface fp_writeback_stage_if #(
  parameter int DATA_W = 32
);
  // ex_valid qualifies every other ex_* field. The WB register takes the
  // instruction on a rising edge only when ex_valid=1, stall=0 and flush=0;
  // stall is the back-pressure (no ready signal), flush kills the capture.
  logic              stall;
  logic              flush;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_fp_result;
  logic [4:0]        ex_fflags;
  logic [4:0]        ex_rd;
  logic              ex_fp_we;
  logic              ex_int_we;
  logic              ex_flags_en;

  modport master (
    output stall, flush, ex_valid, ex_fp_result, ex_fflags, ex_rd,
           ex_fp_we, ex_int_we, ex_flags_en
  );

  modport slave (
    input  stall, flush, ex_valid, ex_fp_result, ex_fflags, ex_rd,
           ex_fp_we, ex_int_we, ex_flags_en
  );
endinterface

// File: rtl/fp_writeback_stage.sv
// FP write-back stage: EX/WB pipeline register, register-file write enables,
// and the fcsr/frm/fflags CSRs with sticky exception-flag accrual.
module fp_writeback_stage #(
  parameter int         DATA_W    = 32,
  parameter logic [2:0] RESET_FRM = 3'b000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_writeback_stage_if.slave  ex,
  input  logic                 csr_en,
  input  logic [1:0]           csr_op,
  input  logic [11:0]          csr_addr,
  input  logic [DATA_W-1:0]    csr_wdata,
  output logic [DATA_W-1:0]    csr_rdata,
  output logic                 wb_valid,
  output logic [4:0]           wb_rd,
  output logic [DATA_W-1:0]    wb_data,
  output logic                 wb_fp_we,
  output logic                 wb_int_we,
  output logic [2:0]           frm,
  output logic [4:0]           fflags
);

  localparam logic [11:0] ADDR_FFLAGS = 12'h001;
  localparam logic [11:0] ADDR_FRM    = 12'h002;
  localparam logic [11:0] ADDR_FCSR   = 12'h003;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic              capture;
  logic              csr_write;
  logic [DATA_W-1:0] csr_new;
  logic [4:0]        fflags_next;
  logic [2:0]        frm_next;

  assign capture   = ex.ex_valid & ~ex.stall & ~ex.flush;
  assign csr_write = csr_en & (csr_op != OP_NONE);

  // Control part of the WB register: flush beats stall beats capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid  <= 1'b0;
      wb_fp_we  <= 1'b0;
      wb_int_we <= 1'b0;
    end else if (ex.flush) begin
      wb_valid  <= 1'b0;
      wb_fp_we  <= 1'b0;
      wb_int_we <= 1'b0;
    end else if (!ex.stall) begin
      wb_valid  <= ex.ex_valid;
      // Both targets set is illegal; the integer file wins.
      wb_fp_we  <= ex.ex_valid & ex.ex_fp_we & ~ex.ex_int_we;
      wb_int_we <= ex.ex_valid & ex.ex_int_we;
    end
  end

  // Payload loads only on capture so bubbles and stalls do not toggle it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rd   <= '0;
      wb_data <= '0;
    end else if (capture) begin
      wb_rd   <= ex.ex_rd;
      wb_data <= ex.ex_fp_result;
    end
  end

  // Combinational CSR read; also the 'old' operand for set/clear.
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_FFLAGS: csr_rdata = {{(DATA_W-5){1'b0}}, fflags};
      ADDR_FRM:    csr_rdata = {{(DATA_W-3){1'b0}}, frm};
      ADDR_FCSR:   csr_rdata = {{(DATA_W-8){1'b0}}, frm, fflags};
      default:     csr_rdata = '0;
    endcase
  end

  always_comb begin
    csr_new = csr_rdata;
    case (csr_op)
      OP_WRITE: csr_new = csr_wdata;
      OP_SET:   csr_new = csr_rdata | csr_wdata;
      OP_CLEAR: csr_new = csr_rdata & ~csr_wdata;
      default:  csr_new = csr_rdata;
    endcase
  end

  // The CSR instruction is older than the captured FP op, so its update is
  // applied first and the op's flags are ORed on top.
  always_comb begin
    fflags_next = fflags;
    frm_next    = frm;
    if (csr_write) begin
      case (csr_addr)
        ADDR_FFLAGS: fflags_next = csr_new[4:0];
        ADDR_FRM:    frm_next    = csr_new[2:0];
        ADDR_FCSR: begin
          fflags_next = csr_new[4:0];
          frm_next    = csr_new[7:5];
        end
        default: begin
          fflags_next = fflags;
          frm_next    = frm;
        end
      endcase
    end
    if (capture && ex.ex_flags_en) begin
      fflags_next = fflags_next | ex.ex_fflags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags <= '0;
      frm    <= RESET_FRM;
    end else begin
      fflags <= fflags_next;
      frm    <= frm_next;
    end
  end

endmodule

// File: tb/tb_fp_writeback_stage.sv
// Directed bench for fp_writeback_stage: reset, capture/bubble, stall/flush,
// flag accrual, CSR ops, CSR/accrual collision and asynchronous reset.
module tb_fp_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_fp_we;
  logic        wb_int_we;
  logic [2:0]  frm;
  logic [4:0]  fflags;

  int checks   = 0;
  int failures = 0;

  fp_writeback_stage_if #(.DATA_W(32)) ex_if ();

  fp_writeback_stage #(.DATA_W(32), .RESET_FRM(3'b000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex        (ex_if),
    .csr_en    (csr_en),
    .csr_op    (csr_op),
    .csr_addr  (csr_addr),
    .csr_wdata (csr_wdata),
    .csr_rdata (csr_rdata),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_fp_we  (wb_fp_we),
    .wb_int_we (wb_int_we),
    .frm       (frm),
    .fflags    (fflags)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_ex(input logic valid, input logic [4:0] rd, input logic [31:0] res,
                          input logic fp_we, input logic int_we, input logic flags_en,
                          input logic [4:0] flags);
    ex_if.ex_valid     = valid;
    ex_if.ex_rd        = rd;
    ex_if.ex_fp_result = res;
    ex_if.ex_fp_we     = fp_we;
    ex_if.ex_int_we    = int_we;
    ex_if.ex_flags_en  = flags_en;
    ex_if.ex_fflags    = flags;
  endtask

  task automatic drive_csr(input logic en, input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] wdata);
    csr_en    = en;
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = wdata;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_if.stall = 1'b0;
    ex_if.flush = 1'b0;
    drive_ex(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'b0);
    drive_csr(1'b0, 2'b00, 12'h003, 32'h0);

    // 1 Reset
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_fp_we", {31'b0, wb_fp_we}, 32'd0);
    check("rst_wb_int_we", {31'b0, wb_int_we}, 32'd0);
    check("rst_fflags", {27'b0, fflags}, 32'd0);
    check("rst_frm", {29'b0, frm}, 32'd0);
    check("rst_rdata_fcsr", csr_rdata, 32'd0);

    // 2 Capture then bubble
    drive_ex(1'b1, 5'd5, 32'h3F80_0000, 1'b1, 1'b0, 1'b0, 5'b0);
    step();
    check("cap_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("cap_wb_fp_we", {31'b0, wb_fp_we}, 32'd1);
    check("cap_wb_int_we", {31'b0, wb_int_we}, 32'd0);
    check("cap_wb_rd", {27'b0, wb_rd}, 32'd5);
    check("cap_wb_data", wb_data, 32'h3F80_0000);
    drive_ex(1'b0, 5'd9, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 5'b0);
    step();
    check("bub_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("bub_wb_fp_we", {31'b0, wb_fp_we}, 32'd0);
    check("bub_wb_data_held", wb_data, 32'h3F80_0000);
    check("bub_wb_rd_held", {27'b0, wb_rd}, 32'd5);

    // 3 Stall then flush
    drive_ex(1'b1, 5'd7, 32'h4000_0000, 1'b1, 1'b0, 1'b0, 5'b0);
    step();
    check("st_cap_rd", {27'b0, wb_rd}, 32'd7);
    drive_ex(1'b1, 5'd9, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 5'b00001);
    ex_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_hold_valid", {31'b0, wb_valid}, 32'd1);
      check("st_hold_rd", {27'b0, wb_rd}, 32'd7);
      check("st_hold_data", wb_data, 32'h4000_0000);
      check("st_no_accrue", {27'b0, fflags}, 32'd0);
    end
    ex_if.flush = 1'b1;
    step();
    check("fl_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("fl_wb_fp_we", {31'b0, wb_fp_we}, 32'd0);
    check("fl_fflags", {27'b0, fflags}, 32'd0);
    check("fl_wb_rd_held", {27'b0, wb_rd}, 32'd7);
    ex_if.stall = 1'b0;
    step();
    check("fl_only_valid", {31'b0, wb_valid}, 32'd0);
    check("fl_only_fflags", {27'b0, fflags}, 32'd0);
    ex_if.flush = 1'b0;

    // 4 Accrual and CSR clear
    drive_ex(1'b1, 5'd1, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 5'b10000);
    step();
    check("acc_first", {27'b0, fflags}, 32'h10);
    drive_ex(1'b1, 5'd2, 32'h0000_0002, 1'b1, 1'b0, 1'b1, 5'b00001);
    step();
    check("acc_second", {27'b0, fflags}, 32'h11);
    drive_ex(1'b1, 5'd3, 32'h0000_0003, 1'b1, 1'b0, 1'b0, 5'b00110);
    step();
    check("acc_flags_en_off", {27'b0, fflags}, 32'h11);
    drive_ex(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'b0);
    drive_csr(1'b1, 2'b11, 12'h001, 32'h0000_0010);
    #1;
    check("clr_rdata_pre", csr_rdata, 32'h11);
    step();
    drive_csr(1'b0, 2'b00, 12'h001, 32'h0);
    check("clr_fflags", {27'b0, fflags}, 32'h01);

    // Illegal dual target: integer write wins
    drive_ex(1'b1, 5'd4, 32'hCAFE_0004, 1'b1, 1'b1, 1'b0, 5'b0);
    step();
    check("dual_int_we", {31'b0, wb_int_we}, 32'd1);
    check("dual_fp_we", {31'b0, wb_fp_we}, 32'd0);
    drive_ex(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'b0);

    // frm set to a reserved value, then an unlisted address
    drive_csr(1'b1, 2'b10, 12'h002, 32'h0000_0005);
    step();
    check("frm_reserved", {29'b0, frm}, 32'h5);
    drive_csr(1'b1, 2'b01, 12'h004, 32'hFFFF_FFFF);
    #1;
    check("bad_addr_rdata", csr_rdata, 32'h0);
    step();
    check("bad_addr_frm", {29'b0, frm}, 32'h5);
    check("bad_addr_fflags", {27'b0, fflags}, 32'h01);
    drive_csr(1'b0, 2'b00, 12'h002, 32'h0);
    #1;
    check("rdata_frm", csr_rdata, 32'h5);

    // 5 Same-cycle CSR write and accrual
    drive_csr(1'b1, 2'b01, 12'h003, 32'h0000_00E0);
    drive_ex(1'b1, 5'd6, 32'h4040_0000, 1'b1, 1'b0, 1'b1, 5'b00100);
    step();
    drive_csr(1'b0, 2'b00, 12'h003, 32'h0);
    drive_ex(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'b0);
    #1;
    check("col_frm", {29'b0, frm}, 32'h7);
    check("col_fflags", {27'b0, fflags}, 32'h04);
    check("col_rdata_fcsr", csr_rdata, 32'h0000_00E4);

    // 6 Asynchronous reset between edges
    drive_ex(1'b1, 5'd12, 32'h4080_0000, 1'b1, 1'b0, 1'b1, 5'b00010);
    step();
    drive_ex(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'b0);
    check("pre_ar_valid", {31'b0, wb_valid}, 32'd1);
    check("pre_ar_fflags", {27'b0, fflags}, 32'h06);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("ar_wb_rd", {27'b0, wb_rd}, 32'd0);
    check("ar_wb_data", wb_data, 32'd0);
    check("ar_wb_fp_we", {31'b0, wb_fp_we}, 32'd0);
    check("ar_fflags", {27'b0, fflags}, 32'd0);
    check("ar_frm", {29'b0, frm}, 32'd0);
    check("ar_rdata_fcsr", csr_rdata, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
